// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: requester and RAM bundle for the round-robin RAM port arbiter.
interface ram_port_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 32,
  parameter int DW   = 32
);
  localparam int IW = $clog2(NREQ);
  logic [NREQ-1:0]    req_ren;
  logic [NREQ-1:0]    req_wen;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_store;
  logic [NREQ-1:0]    req_wait;
  logic [DW-1:0]      req_load;
  logic               ramREN;
  logic               ramWEN;
  logic [AW-1:0]      ramaddr;
  logic [DW-1:0]      ramstore;
  logic [DW-1:0]      ramload;
  logic [1:0]         ramstate;
  logic [IW-1:0]      grant_id;
  logic               grant_vld;
  modport slave (
    input  req_ren, req_wen, req_addr, req_store, ramload, ramstate,
    output req_wait, req_load, ramREN, ramWEN, ramaddr, ramstore, grant_id, grant_vld
  );
  modport master (
    output req_ren, req_wen, req_addr, req_store, ramload, ramstate,
    input  req_wait, req_load, ramREN, ramWEN, ramaddr, ramstore, grant_id, grant_vld
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin grant of one RAM port to NREQ cache requesters, held until ACCESS.
// Define ARB_DPRIO_EN to give dcache (odd-index) requesters priority over icache requesters.
module ram_port_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 32,
  parameter int DW   = 32
) (
  input logic CLK,
  input logic nRST,
  ram_port_arbiter_if.slave bus
);
  localparam int IW = $clog2(NREQ);
  localparam logic [1:0] ACCESS = 2'd2;
  typedef enum logic {IDLE, GRANT} state_t;
  state_t          state_q;
  logic [IW-1:0]   rr_ptr_q, grant_id_q, win, next_ptr;
  logic [NREQ-1:0] pend;
  logic            gnt, done;
  int              k;
  assign pend = bus.req_ren | bus.req_wen;
  // descending scan so the pending index closest to rr_ptr is assigned last
  always_comb begin
    win = rr_ptr_q;
    k = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      k = (int'(rr_ptr_q) + i) % NREQ;
      if (pend[k]) win = IW'(k);
    end
`ifdef ARB_DPRIO_EN
    for (int i = NREQ - 1; i >= 0; i--) begin
      k = (int'(rr_ptr_q) + i) % NREQ;
      if (pend[k] && k[0]) win = IW'(k);
    end
`else
`endif
  end
  assign next_ptr = (grant_id_q == IW'(NREQ - 1)) ? '0 : grant_id_q + 1'b1;
  always_ff @(posedge CLK)
    if (!nRST) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
    end else if (state_q == IDLE) begin
      if (|pend) begin
        state_q    <= GRANT;
        grant_id_q <= win;
      end
    end else if (bus.ramstate == ACCESS || !pend[grant_id_q]) begin
      state_q  <= IDLE;
      rr_ptr_q <= next_ptr;
    end
  assign gnt           = state_q == GRANT;
  // a reset cycle never signals completion
  assign done          = gnt && bus.ramstate == ACCESS && nRST;
  assign bus.ramaddr   = gnt ? bus.req_addr[int'(grant_id_q)*AW +: AW] : '0;
  assign bus.ramstore  = gnt ? bus.req_store[int'(grant_id_q)*DW +: DW] : '0;
  assign bus.ramWEN    = gnt & bus.req_wen[grant_id_q];
  assign bus.ramREN    = gnt & bus.req_ren[grant_id_q] & ~bus.req_wen[grant_id_q];
  assign bus.req_wait  = ~(NREQ'(done) << grant_id_q);
  assign bus.req_load  = bus.ramload;
  assign bus.grant_id  = grant_id_q;
  assign bus.grant_vld = gnt;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: randomized scenarios checked against a transaction-level arbiter model.
module tb_ram_port_arbiter;
  localparam int N = 4, AW = 32, DW = 32;
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;
  logic clk = 0, nrst = 0;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  ram_port_arbiter_if #(.NREQ(N), .AW(AW), .DW(DW)) b();
  ram_port_arbiter #(.NREQ(N), .AW(AW), .DW(DW)) dut (.CLK(clk), .nRST(nrst), .bus(b));
  wire [104:0] got_v = {b.ramREN, b.ramWEN, b.ramaddr, b.ramstore, b.req_wait, b.grant_vld,
                        b.grant_vld ? b.grant_id : 2'b0, b.req_load};
  logic [104:0] exp_v;
  bit m_busy;
  int m_g, m_rr;
  function automatic int pick(logic [N-1:0] p, int rr);
    int best = -1, bd = N;
    bit odd_only = 0;
`ifdef ARB_DPRIO_EN
    for (int i = 1; i < N; i += 2) if (p[i]) odd_only = 1;
`endif
    for (int i = 0; i < N; i++)
      if (p[i] && (!odd_only || i % 2 == 1) && (i - rr + N) % N < bd) begin
        best = i;
        bd = (i - rr + N) % N;
      end
    return best;
  endfunction
  task automatic model_eval();
    logic [N-1:0] w = '1;
    logic [AW-1:0] a = '0;
    logic [DW-1:0] s = '0;
    logic re = 0, we = 0;
    if (m_busy) begin
      a = b.req_addr[m_g*AW +: AW];
      s = b.req_store[m_g*DW +: DW];
      we = b.req_wen[m_g];
      re = b.req_ren[m_g] & ~we;
      if (nrst && b.ramstate == ACCESS) w[m_g] = 0;
    end
    exp_v = {re, we, a, s, w, m_busy, m_busy ? 2'(m_g) : 2'b0, b.ramload};
  endtask
  task automatic model_step();
    logic [N-1:0] p = b.req_ren | b.req_wen;
    if (!nrst) begin
      m_busy = 0; m_rr = 0; m_g = 0;
    end else if (!m_busy) begin
      if (p != 0) begin m_g = pick(p, m_rr); m_busy = 1; end
    end else if (b.ramstate == ACCESS || !p[m_g]) begin
      m_busy = 0; m_rr = (m_g + 1) % N;
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask
  task automatic rnd_data();
    b.req_addr  = {$urandom, $urandom, $urandom, $urandom};
    b.req_store = {$urandom, $urandom, $urandom, $urandom};
    b.ramload   = $urandom;
  endtask
  task automatic do_reset();
    nrst = 0; b.req_ren = '0; b.req_wen = '0; b.ramstate = FREE; rnd_data();
    tick(); tick();
    nrst = 1;
  endtask
  task automatic test_reset();
    nrst = 0; b.req_ren = '0; b.req_wen = '0; b.ramstate = FREE; rnd_data();
    tick(); tick();
    nrst = 1;
    @(negedge clk); model_eval();
    checks++;
    if (got_v !== exp_v) begin failures++; $display("FAIL reset_model got=%h exp=%h", got_v, exp_v); end
    checks++;
    if ({b.ramREN, b.ramWEN, b.req_wait, b.grant_vld, b.ramaddr, dut.rr_ptr_q} !== {2'b00, 4'hF, 1'b0, 32'h0, 2'd0}) begin
      failures++;
      $display("FAIL reset_state got ren=%b wen=%b wait=%b vld=%b addr=%h rr=%0d exp 0 0 1111 0 0 0",
               b.ramREN, b.ramWEN, b.req_wait, b.grant_vld, b.ramaddr, dut.rr_ptr_q);
    end
    tick();
  endtask
  task automatic test_single_read();
    int low = 0;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      b.req_ren = c < 4 ? 4'b0010 : 4'b0000;
      rnd_data();
      b.req_addr[AW +: AW] = 32'h40;
      b.ramstate = c == 3 ? ACCESS : BUSY;
      if (c == 3) b.ramload = 32'hDEAD_BEEF;
      @(negedge clk); model_eval();
      checks++;
      if (got_v !== exp_v) begin failures++; $display("FAIL read_model c=%0d got=%h exp=%h", c, got_v, exp_v); end
      if (c >= 1 && c <= 3) begin
        checks++;
        if ({b.ramREN, b.ramaddr} !== {1'b1, 32'h40}) begin
          failures++; $display("FAIL read_en c=%0d got ren=%b addr=%h exp 1 00000040", c, b.ramREN, b.ramaddr);
        end
      end
      if (!b.req_wait[1]) begin
        low++;
        checks++;
        if (b.req_load !== 32'hDEAD_BEEF) begin failures++; $display("FAIL read_load got=%h exp=deadbeef", b.req_load); end
      end
      tick();
    end
    checks++;
    if (low !== 1) begin failures++; $display("FAIL read_wait_pulses got=%0d exp=1", low); end
    checks++;
    if (dut.rr_ptr_q !== 2'd2) begin failures++; $display("FAIL read_rr got=%0d exp=2", dut.rr_ptr_q); end
  endtask
  task automatic test_round_robin();
    int order[$], at[$];
    do_reset();
    for (int c = 0; c < 10; c++) begin
      b.req_ren = '1; b.req_wen = N'($urandom); rnd_data(); b.ramstate = ACCESS;
      @(negedge clk); model_eval();
      checks++;
      if (got_v !== exp_v) begin failures++; $display("FAIL rr_model c=%0d got=%h exp=%h", c, got_v, exp_v); end
      for (int i = 0; i < N; i++) if (!b.req_wait[i]) begin order.push_back(i); at.push_back(c); end
      tick();
    end
    checks++;
    if (order.size() !== 5) begin failures++; $display("FAIL rr_count got=%0d exp=5", order.size()); end
    for (int k = 0; k < order.size() && k < 5; k++) begin
      checks++;
      if (order[k] !== k % N || at[k] !== 2 * k + 1) begin
        failures++; $display("FAIL rr_order k=%0d got id=%0d cyc=%0d exp id=%0d cyc=%0d", k, order[k], at[k], k % N, 2 * k + 1);
      end
    end
  endtask
  task automatic test_write_priority();
    int pulses = 0;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      b.req_ren = c < 3 ? 4'b0100 : 4'b0; b.req_wen = b.req_ren; rnd_data();
      b.req_store[2*DW +: DW] = 32'h1234;
      b.ramstate = c == 2 ? ACCESS : BUSY;
      @(negedge clk); model_eval();
      checks++;
      if (got_v !== exp_v) begin failures++; $display("FAIL wr_model c=%0d got=%h exp=%h", c, got_v, exp_v); end
      if (c == 1) begin
        checks++;
        if ({b.ramREN, b.ramWEN, b.ramstore} !== {2'b01, 32'h1234}) begin
          failures++; $display("FAIL wr_prio got ren=%b wen=%b store=%h exp 0 1 00001234", b.ramREN, b.ramWEN, b.ramstore);
        end
      end
      tick();
    end
    do_reset();
    for (int c = 0; c < 5; c++) begin
      b.req_ren = '0; b.req_wen = c < 2 ? 4'b0100 : 4'b0; rnd_data(); b.ramstate = BUSY;
      @(negedge clk); model_eval();
      checks++;
      if (got_v !== exp_v) begin failures++; $display("FAIL wd_model c=%0d got=%h exp=%h", c, got_v, exp_v); end
      if (b.req_wait !== 4'hF) pulses++;
      if (c == 3) begin
        checks++;
        if (b.grant_vld !== 1'b0) begin failures++; $display("FAIL wd_idle got vld=%b exp=0", b.grant_vld); end
      end
      tick();
    end
    checks++;
    if (pulses !== 0 || dut.rr_ptr_q !== 2'd3) begin
      failures++; $display("FAIL wd_abort got pulses=%0d rr=%0d exp 0 3", pulses, dut.rr_ptr_q);
    end
  endtask
  task automatic test_error_hold();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      b.req_ren = c < 7 ? 4'b1000 : 4'b0; rnd_data();
      b.ramstate = (c >= 1 && c <= 5) ? ERROR : c == 6 ? ACCESS : FREE;
      @(negedge clk); model_eval();
      checks++;
      if (got_v !== exp_v) begin failures++; $display("FAIL err_model c=%0d got=%h exp=%h", c, got_v, exp_v); end
      if (c >= 1 && c <= 6) begin
        checks++;
        if ({b.grant_vld, b.grant_id, b.req_wait[3]} !== {1'b1, 2'd3, c == 6 ? 1'b0 : 1'b1}) begin
          failures++; $display("FAIL err_hold c=%0d got vld=%b id=%0d wait3=%b", c, b.grant_vld, b.grant_id, b.req_wait[3]);
        end
      end
      tick();
    end
    checks++;
    if (dut.rr_ptr_q !== 2'd0) begin failures++; $display("FAIL err_wrap got rr=%0d exp=0", dut.rr_ptr_q); end
  endtask
  task automatic test_dprio();
    logic [N-1:0] act = 4'b1001;
    int first = -1, second = -1, e1, e2;
`ifdef ARB_DPRIO_EN
    e1 = 3; e2 = 0;
`else
    e1 = 0; e2 = 3;
`endif
    do_reset();
    for (int c = 0; c < 6; c++) begin
      b.req_ren = act; b.req_wen = '0; rnd_data(); b.ramstate = ACCESS;
      @(negedge clk); model_eval();
      checks++;
      if (got_v !== exp_v) begin failures++; $display("FAIL prio_model c=%0d got=%h exp=%h", c, got_v, exp_v); end
      for (int i = 0; i < N; i++)
        if (!b.req_wait[i]) begin
          if (first < 0) first = i; else if (second < 0) second = i;
          act[i] = 1'b0;
        end
      tick();
    end
    checks++;
    if (first !== e1 || second !== e2) begin
      failures++; $display("FAIL prio_order got %0d,%0d exp %0d,%0d", first, second, e1, e2);
    end
  endtask
  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      nrst = $urandom_range(0, 79) != 0;
      if ($urandom_range(0, 3) == 0) begin b.req_ren = N'($urandom & $urandom); b.req_wen = N'($urandom & $urandom); end
      rnd_data();
      b.ramstate = 2'($urandom);
      @(negedge clk); model_eval();
      checks++;
      if (got_v !== exp_v || int'(dut.rr_ptr_q) !== m_rr) begin
        failures++; $display("FAIL rand_model c=%0d got=%h rr=%0d exp=%h rr=%0d", c, got_v, dut.rr_ptr_q, exp_v, m_rr);
      end
      tick();
    end
    nrst = 1;
  endtask
  initial begin
    b.req_ren = '0; b.req_wen = '0; b.ramstate = FREE; rnd_data();
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_priority();
    test_error_hold();
    test_dprio();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
